// File: rtl/mp_addsub_arb_seq_if.sv
// rtl/mp_addsub_arb_seq_if.sv - command/result bundle for mp_addsub_arb_seq
// Purpose: groups the two requester command ports and the tagged result port.
// Ports (slave = arithmetic sequencer side, master = requesters/consumer side):
//   i_req0_valid/o_req0_ready/i_req0_a/i_req0_b/i_req0_sub : requester 0 command
//   i_req1_valid/o_req1_ready/i_req1_a/i_req1_b/i_req1_sub : requester 1 command
//   o_res_valid/i_res_ready/o_res_sum/o_res_cout/o_res_ovf/o_res_id : result
//   o_busy : sequencer not idle
interface mp_addsub_arb_seq_if #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
);
  localparam int N = WIDTH * WORDS;

  logic         i_req0_valid;
  logic         o_req0_ready;
  logic [N-1:0] i_req0_a;
  logic [N-1:0] i_req0_b;
  logic         i_req0_sub;

  logic         i_req1_valid;
  logic         o_req1_ready;
  logic [N-1:0] i_req1_a;
  logic [N-1:0] i_req1_b;
  logic         i_req1_sub;

  logic         o_res_valid;
  logic         i_res_ready;
  logic [N-1:0] o_res_sum;
  logic         o_res_cout;
  logic         o_res_ovf;
  logic         o_res_id;
  logic         o_busy;

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_sub,
    output o_req0_ready,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_sub,
    output o_req1_ready,
    output o_res_valid, o_res_sum, o_res_cout, o_res_ovf, o_res_id, o_busy,
    input  i_res_ready
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_sub,
    input  o_req0_ready,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_sub,
    input  o_req1_ready,
    input  o_res_valid, o_res_sum, o_res_cout, o_res_ovf, o_res_id, o_busy,
    output i_res_ready
  );
endinterface

// File: rtl/mp_addsub_arb_seq.sv
// rtl/mp_addsub_arb_seq.sv - two-requester round-robin multi-precision add/sub sequencer
// Purpose: shares one WIDTH-bit add/sub slice between two requesters and walks a
//   WORDS-slice add or subtract through it, least-significant slice first.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : mp_addsub_arb_seq_if.slave (commands in, tagged result out, busy)

module add_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_add_sub,
  input  logic             i_cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);
  logic [WIDTH-1:0] b_eff;

  // Subtract is A + ~B + cin; the caller supplies cin=1 on the first slice.
  assign b_eff = i_add_sub ? ~i_b : i_b;
  assign {c_out, sum_out} = {1'b0, i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, i_cin};
endmodule

module mp_addsub_arb_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input logic                i_clk,
  input logic                i_rst_n,
  mp_addsub_arb_seq_if.slave bus
);
  localparam int N   = WIDTH * WORDS;
  localparam int K_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic           rr_ptr;     // 1 = requester 1 wins the next tie
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic           sub_reg;
  logic           id_reg;
  logic [K_W-1:0] k;
  logic           carry_reg;
  logic [N-1:0]   sum_reg;
  logic           cout_reg;
  logic           ovf_reg;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cin;
  logic             slice_cout;
  logic             slice_ovf;

  // Grants are combinational so the ready lands in the same IDLE cycle as the
  // valid; gating with reset keeps both readies low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_rst_n && state == S_IDLE) begin
      grant0 = bus.i_req0_valid && (!bus.i_req1_valid || !rr_ptr);
      grant1 = bus.i_req1_valid && (!bus.i_req0_valid ||  rr_ptr);
    end
  end

  assign bus.o_req0_ready = grant0;
  assign bus.o_req1_ready = grant1;

  assign slice_a   = a_reg[k * WIDTH +: WIDTH];
  assign slice_b   = b_reg[k * WIDTH +: WIDTH];
  assign slice_cin = (k == '0) ? sub_reg : carry_reg;

  add_sub #(.WIDTH(WIDTH)) u_slice (
    .i_a       (slice_a),
    .i_b       (slice_b),
    .i_add_sub (sub_reg),
    .i_cin     (slice_cin),
    .sum_out   (slice_sum),
    .c_out     (slice_cout)
  );

  // Signed overflow: operands (B inverted for subtract) agree in sign and the
  // result sign differs from A. Only meaningful on the top slice.
  assign slice_ovf = (slice_a[WIDTH-1] ~^ (slice_b[WIDTH-1] ^ sub_reg)) &
                     (slice_a[WIDTH-1] ^ slice_sum[WIDTH-1]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      id_reg    <= 1'b0;
      k         <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            a_reg   <= grant1 ? bus.i_req1_a   : bus.i_req0_a;
            b_reg   <= grant1 ? bus.i_req1_b   : bus.i_req0_b;
            sub_reg <= grant1 ? bus.i_req1_sub : bus.i_req0_sub;
            id_reg  <= grant1;
            rr_ptr  <= ~grant1;
            k       <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum_reg[k * WIDTH +: WIDTH] <= slice_sum;
          carry_reg <= slice_cout;
          if (k == K_LAST) begin
            cout_reg <= slice_cout;
            ovf_reg  <= slice_ovf;
            state    <= S_DONE;
          end else begin
            k <= k + K_W'(1);
          end
        end
        S_DONE: begin
          if (bus.i_res_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_res_valid = (state == S_DONE);
  assign bus.o_res_sum   = sum_reg;
  assign bus.o_res_cout  = cout_reg;
  assign bus.o_res_ovf   = ovf_reg;
  assign bus.o_res_id    = id_reg;
  assign bus.o_busy      = (state != S_IDLE);
endmodule

// File: doc/mp_addsub_arb_seq.md
Name: mp_addsub_arb_seq

Overview:
- Shares one 8-bit Add_Sub slice between two requesters and sequences multi-precision add/subtract (WORDS x WIDTH bits) through it, one slice per cycle, least-significant slice first.
- Each requester uses a valid/ready command port. The single result port uses valid/ready and tags each result with the requester id.
- Sits between the command sources and the arithmetic datapath.

Parameters:
- WIDTH, 8, slice width of the instantiated Add_Sub; fixed at 8.
- WORDS, 4, slices per operation; operand width N = WIDTH*WORDS; legal range 1..16.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req0_valid  in  1  requester 0 command valid.
- o_req0_ready  out  1  requester 0 command accepted this cycle.
- i_req0_a  in  N  requester 0 operand A.
- i_req0_b  in  N  requester 0 operand B.
- i_req0_sub  in  1  requester 0 operation: 1 = A-B, 0 = A+B.
- i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_sub: same as requester 0, for requester 1.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result consumer ready.
- o_res_sum  out  N  result A+B or A-B, mod 2^N.
- o_res_cout  out  1  final carry (subtract: 1 = no borrow).
- o_res_ovf  out  1  signed two's-complement overflow.
- o_res_id  out  1  requester that issued the result.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_rst_n low at a clock edge): FSM goes to IDLE and the RR pointer favours req0. All outputs are 0: o_res_valid, o_res_sum, o_res_cout, o_res_ovf, o_res_id, o_busy, both readies. The operand registers and the slice counter clear.
- FSM states:
  - IDLE: if any valid, grant one requester. The grant asserts that requester's ready in the same cycle (combinational from valid and pointer). The block latches A, B, sub and id, clears the slice counter k, and goes to RUN. With no valid it stays in IDLE.
  - RUN: one slice per cycle. Add_Sub gets i_a = A[k], i_b = B[k], i_add_sub = sub, i_cin = (k==0 ? sub : carry_reg). The block stores sum_out into result slice k and c_out into carry_reg.
    - On k == WORDS-1 it computes ovf = (A_msb ~^ (B_msb^sub)) & (A_msb ^ sum_msb), registers cout and ovf, and goes to DONE.
    - Otherwise k increments.
  - DONE: o_res_valid high. Sum, cout, ovf and id stay stable until i_res_ready is high, then the FSM returns to IDLE and o_res_valid drops next cycle.
- Readies are never asserted outside IDLE. Requester valids are ignored in RUN and DONE. Requesters must hold their operands stable until ready.
- Arbitration (round-robin):
  - If only one valid, it wins.
  - If both are valid, the requester not granted last wins. The pointer updates on every grant.
  - After reset, req0 wins a tie.
- Latency: command accepted at edge T; o_res_valid high from cycle T+WORDS+1. Best-case throughput is one operation per WORDS+2 cycles, with i_res_ready tied high.
- There is no DONE-to-grant bypass. A command pending during DONE is granted in the IDLE cycle that follows.
- i_res_ready while o_res_valid is low has no effect.
- Reset mid-RUN or mid-DONE aborts the operation. The in-flight result is discarded (never presented), and the RR pointer returns to its req0-favoured reset value.
- WORDS=1: RUN lasts one cycle and the first-slice carry rule applies.
- Wrap-around: the sum is mod 2^N. Carry out of the top slice appears only on o_res_cout.

Test Plan:
- WORDS=4, req0 add A=0xFFFFFFFF, B=0x00000001 -> sum 0x00000000, cout 1, ovf 0, id 0, valid exactly 5 cycles after accept.
- req1 sub A=0x00000000, B=0x00000001 -> sum 0xFFFFFFFF, cout 0 (borrow), ovf 0, id 1. Then sub A=0x80000000, B=0x00000001 -> sum 0x7FFFFFFF, ovf 1, cout 1.
- req0 add A=0x7FFFFFFF, B=0x00000001 -> sum 0x80000000, ovf 1, cout 0. Also A=0x12345678 + B=0x0F0F0F0F -> sum 0x21436587, cout 0, ovf 0.
- Fairness and backpressure:
  - Both valid continuously from reset -> grants alternate 0,1,0,1 over 4 results, and ids match.
  - Hold i_res_ready low 3 cycles in DONE -> o_res_valid and all result fields stay stable, and no ready is asserted.
- Reset abort: assert i_rst_n=0 for one edge when k=2 during RUN -> next cycle FSM is in IDLE and o_busy=0. No result is ever presented for that command. A new command completes normally and req0 wins a tie.
